overlay_stream_blend: RTL and testbench

Streams a per-pixel RGBA overlay picture from a word-wide memory read channel and composites it with the vector beam colour, one pixel per `ce_pix` during active video. It is the parametrised successor of the single-channel RGBA4444 overlay fetch/blend path in the Vectrex top level, and sits between the SDRAM read channel and the VGA colour outputs. Compared with that path it generalises the following:

- channel depth and pixels per memory word are parameters;
- fetched words are buffered in a FIFO of configurable depth;
- underruns are handled without stream misalignment;
- in-flight reads are discarded cleanly at frame start.

---
 rtl/overlay_stream_blend.sv | 174 +++++++++++++++++
 tb/tb_overlay_stream_blend.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/overlay_stream_blend.sv
// rtl/overlay_stream_blend.sv - overlay word fetch, FIFO, pixel unpack and beam blend
module overlay_stream_blend #(
  parameter int CH_BITS     = 4,
  parameter int WORD_PIX    = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 24,
  parameter int TINT_THRESH = 108
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic                            ce_pix,
  input  logic                            enable,
  input  logic                            hblank,
  input  logic                            vblank,
  input  logic                            vsync,
  input  logic [ADDR_W-1:0]               base_addr,
  output logic                            mem_req,
  output logic [ADDR_W-1:0]               mem_addr,
  input  logic                            mem_ack,
  input  logic [4*CH_BITS*WORD_PIX-1:0]   mem_data,
  input  logic [7:0]                      beam_r,
  input  logic [7:0]                      beam_g,
  input  logic [7:0]                      beam_b,
  input  logic                            alpha_en,
  input  logic                            color_vec,
  input  logic                            tint_en,
  output logic [7:0]                      out_r,
  output logic [7:0]                      out_g,
  output logic [7:0]                      out_b,
  output logic                            underrun
);

  localparam int PIX_W  = 4 * CH_BITS;
  localparam int WORD_W = PIX_W * WORD_PIX;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUB_W  = (WORD_PIX > 1) ? $clog2(WORD_PIX) : 1;

  logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, skip;
  logic [SUB_W-1:0]  sub, sub_next;
  logic              discard, vsync_d;
  logic [PIX_W-1:0]  ov_pix, head_pix;
  logic [WORD_W-1:0] head_word;

  logic frame_start, active, ack, ack_drop, ack_skip, push;
  logic pop_slot, fifo_empty, sub_last, pop, skip_inc;
  logic fg, bgp, sel_ov, tint;
  logic [7:0] o_r, o_g, o_b, o_a;
  logic [7:0] blend_r, blend_g, blend_b;

  // MSB-first bit replication of one channel up to 8 bits
  function automatic logic [7:0] expand(input logic [CH_BITS-1:0] ch);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) e[7-i] = ch[CH_BITS-1-(i % CH_BITS)];
    return e;
  endfunction

  // Beam-priority composite with optional white tint, else alpha-scaled overlay
  function automatic logic [7:0] blend_ch(input logic [7:0] o8, input logic [7:0] beam_c,
                                          input logic [7:0] a8, input logic fg_i,
                                          input logic sel_i, input logic tint_i,
                                          input logic alpha_i);
    logic [7:0]  base;
    logic [7:0]  inv;
    logic [16:0] prod;
    base = sel_i ? o8 : beam_c;
    inv  = 8'd255 - base;
    prod = 17'(o8) * (17'(a8) + 17'd1);
    if (fg_i) return tint_i ? base + (inv >> 1) + (inv >> 2) : base;
    return alpha_i ? 8'(prod >> 8) : o8;
  endfunction

  // Event decode: frame start, ack classification, pop slot and FIFO head pixel
  always_comb begin
    frame_start = vsync & ~vsync_d;
    active      = ~(hblank | vblank);
    ack         = mem_req & mem_ack;
    ack_drop    = ack & (discard | frame_start);
    ack_skip    = ack & ~ack_drop & (skip != '0);
    push        = ack & ~ack_drop & ~ack_skip;
    pop_slot    = ce_pix & active & enable & ~frame_start;
    fifo_empty  = (count == '0);
    sub_last    = (sub == SUB_W'(WORD_PIX - 1));
    sub_next    = sub_last ? '0 : sub + SUB_W'(1);
    pop         = pop_slot & ~fifo_empty & sub_last;
    skip_inc    = pop_slot & fifo_empty & sub_last & (skip != CNT_W'(FIFO_DEPTH));
    head_word   = fifo_mem[rd_ptr];
    head_pix    = head_word[int'(sub)*PIX_W +: PIX_W];
  end

  // Channel expansion and blend of the current overlay pixel with the beam
  always_comb begin
    o_r     = expand(ov_pix[CH_BITS-1:0]);
    o_g     = expand(ov_pix[2*CH_BITS-1:CH_BITS]);
    o_b     = expand(ov_pix[3*CH_BITS-1:2*CH_BITS]);
    o_a     = expand(ov_pix[4*CH_BITS-1:3*CH_BITS]);
    fg      = |{beam_r, beam_g, beam_b};
    bgp     = |ov_pix[3*CH_BITS-1:0];
    sel_ov  = color_vec & bgp;
    tint    = tint_en & (int'(beam_r) > TINT_THRESH);
    blend_r = blend_ch(o_r, beam_r, o_a, fg, sel_ov, tint, alpha_en);
    blend_g = blend_ch(o_g, beam_g, o_a, fg, sel_ov, tint, alpha_en);
    blend_b = blend_ch(o_b, beam_b, o_a, fg, sel_ov, tint, alpha_en);
  end

  // FIFO storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= mem_data;
  end

  // Fetcher, FIFO bookkeeping, pixel pop, skip/discard tracking and output register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vsync_d  <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      discard  <= 1'b0;
      skip     <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sub      <= '0;
      ov_pix   <= '0;
      underrun <= 1'b0;
      out_r    <= 8'd0;
      out_g    <= 8'd0;
      out_b    <= 8'd0;
    end else begin
      vsync_d <= vsync;

      // Single outstanding read; only the FIFO count matters since no read is in flight
      if (ack) mem_req <= 1'b0;
      else if (!mem_req && enable && !frame_start && count < CNT_W'(FIFO_DEPTH)) mem_req <= 1'b1;

      // Address must stay put while a request is up, so a restart during a read
      // reloads base_addr only when that read's ack arrives
      if (frame_start && !mem_req) mem_addr <= base_addr;
      else if (ack_drop)           mem_addr <= base_addr;
      else if (ack)                mem_addr <= mem_addr + ADDR_W'(1);

      if (ack)                         discard <= 1'b0;
      else if (frame_start && mem_req) discard <= 1'b1;

      if (frame_start) skip <= '0;
      else if (ack_skip && !skip_inc) skip <= skip - CNT_W'(1);
      else if (skip_inc && !ack_skip) skip <= skip + CNT_W'(1);

      if (frame_start) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        sub    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
        if (pop_slot) sub <= sub_next;
      end

      if (pop_slot) ov_pix <= fifo_empty ? '0 : head_pix;
      else if (ce_pix && !(active && enable)) ov_pix <= '0;

      if (frame_start) underrun <= 1'b0;
      else if (pop_slot && fifo_empty) underrun <= 1'b1;

      out_r <= blend_r;
      out_g <= blend_g;
      out_b <= blend_b;
    end
  end

endmodule

// File: tb/tb_overlay_stream_blend.sv
// tb/tb_overlay_stream_blend.sv - directed scoreboard bench for overlay_stream_blend
module tb_overlay_stream_blend;

  logic        clk_sys = 1'b0;
  logic        reset, ce_pix, enable, hblank, vblank, vsync;
  logic [23:0] base_addr;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [7:0]  beam_r, beam_g, beam_b;
  logic        alpha_en, color_vec, tint_en;
  logic [7:0]  out_r, out_g, out_b;
  logic        underrun;

  int          checks = 0;
  int          failures = 0;
  int          mode = 0;
  logic        ack_hold = 1'b0;
  logic [23:0] ack_addrs[$];
  logic [7:0]  exp_q[$];
  int          n0;

  overlay_stream_blend dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .enable(enable),
    .hblank(hblank), .vblank(vblank), .vsync(vsync), .base_addr(base_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .beam_r(beam_r), .beam_g(beam_g), .beam_b(beam_b),
    .alpha_en(alpha_en), .color_vec(color_vec), .tint_en(tint_en),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .underrun(underrun)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    case (mode)
      1:       return (a == 24'd0) ? {16'hF00F, 16'h800F} : {16'h000F, 16'h000F};
      2:       return {16'h0004, 16'h0004};
      default: return {16'h4321 + a[15:0], 16'hF000 + a[15:0]};
    endcase
  endfunction

  // Memory model: one-cycle ack pulse one clock after a visible request
  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_req && !ack_hold) begin
        mem_ack  = 1'b1;
        mem_data = mem_word(mem_addr);
        ack_addrs.push_back(mem_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  task automatic vsync_pulse();
    @(negedge clk_sys) vsync = 1'b1;
    wait_neg(2);
    vsync = 1'b0;
    wait_neg(1);
  endtask

  task automatic pixel(input string tag, input logic [7:0] exp);
    @(negedge clk_sys);
    hblank = 1'b0; vblank = 1'b0; ce_pix = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk_sys);
    ce_pix = 1'b0; hblank = 1'b1; vblank = 1'b1;
    wait_neg(2);
    check(tag, {24'd0, out_r}, {24'd0, exp_q.pop_front()});
  endtask

  initial begin
    reset = 1'b1; ce_pix = 1'b0; enable = 1'b0; hblank = 1'b1; vblank = 1'b1;
    vsync = 1'b0; base_addr = 24'd0; beam_r = 8'd0; beam_g = 8'd0; beam_b = 8'd0;
    alpha_en = 1'b0; color_vec = 1'b0; tint_en = 1'b0;
    wait_neg(3);
    reset = 1'b0;
    wait_neg(2);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
    check("rst_out_r", {24'd0, out_r}, 32'd0);
    check("rst_out_g", {24'd0, out_g}, 32'd0);
    check("rst_out_b", {24'd0, out_b}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);

    // Stream: r nibbles 0,1,1,2,2,3 across three words
    vsync_pulse();
    enable = 1'b1;
    wait_neg(40);
    pixel("stream_px0", 8'h00);
    pixel("stream_px1", 8'h11);
    pixel("stream_px2", 8'h11);
    pixel("stream_px3", 8'h22);
    pixel("stream_px4", 8'h22);
    pixel("stream_px5", 8'h33);
    wait_neg(30);
    check("stream_acks", ack_addrs.size(), 32'd11);
    check("stream_no_underrun", {31'd0, underrun}, 32'd0);

    // Alpha scaling
    mode = 1; alpha_en = 1'b1;
    vsync_pulse();
    wait_neg(40);
    pixel("alpha_a8", 8'd136);
    pixel("alpha_aF", 8'd255);
    pixel("alpha_a0", 8'd0);
    alpha_en = 1'b0;

    // Tint over beam colour
    mode = 2; color_vec = 1'b1; tint_en = 1'b1; beam_r = 8'd200;
    vsync_pulse();
    wait_neg(40);
    pixel("tint_200", 8'd207);
    beam_r = 8'd100;
    pixel("tint_100", 8'd68);
    color_vec = 1'b0; beam_r = 8'd200;
    pixel("tint_beam", 8'd240);
    color_vec = 1'b0; tint_en = 1'b0; beam_r = 8'd0;

    // Underrun for two words, then realignment through skip
    mode = 0; ack_hold = 1'b1;
    vsync_pulse();
    wait_neg(4);
    pixel("urun_px0", 8'h00);
    pixel("urun_px1", 8'h00);
    pixel("urun_px2", 8'h00);
    pixel("urun_px3", 8'h00);
    check("urun_flag", {31'd0, underrun}, 32'd1);
    ack_hold = 1'b0;
    wait_neg(40);
    pixel("urun_px4", 8'h22);
    pixel("urun_px5", 8'h33);

    // Frame restart with a read outstanding
    ack_hold = 1'b1; base_addr = 24'h000100;
    vsync_pulse();
    wait_neg(3);
    check("restart_urun_clr0", {31'd0, underrun}, 32'd0);
    pixel("restart_empty", 8'h00);
    check("restart_urun_set", {31'd0, underrun}, 32'd1);
    base_addr = 24'h000203;
    vsync_pulse();
    check("restart_req_held", {31'd0, mem_req}, 32'd1);
    check("restart_addr_stable", {8'd0, mem_addr}, 32'h000100);
    check("restart_urun_clr", {31'd0, underrun}, 32'd0);
    n0 = ack_addrs.size();
    ack_hold = 1'b0;
    wait_neg(40);
    check("restart_ack_count", {31'd0, ack_addrs.size() > n0 + 1}, 32'd1);
    if (ack_addrs.size() > n0 + 1) begin
      check("restart_discard_addr", {8'd0, ack_addrs[n0]}, 32'h000100);
      check("restart_next_addr", {8'd0, ack_addrs[n0+1]}, 32'h000203);
    end
    pixel("restart_px0", 8'h33);
    pixel("restart_px1", 8'h44);

    // Reset mid-frame with a read outstanding
    ack_hold = 1'b1; beam_r = 8'h55;
    vsync_pulse();
    wait_neg(3);
    pixel("midrst_beam", 8'h55);
    check("midrst_urun_pre", {31'd0, underrun}, 32'd1);
    check("midrst_req_pre", {31'd0, mem_req}, 32'd1);
    @(negedge clk_sys) reset = 1'b1;
    @(negedge clk_sys);
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_mem_addr", {8'd0, mem_addr}, 32'd0);
    check("midrst_out_r", {24'd0, out_r}, 32'd0);
    check("midrst_underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b0; ack_hold = 1'b0;
    wait_neg(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
